// File: rtl/led_anim_pkg.sv
// Shared types for the LED-bar animator: animation mode codes and FSM state encoding.
package led_anim_pkg;

    typedef enum logic [1:0] {
        MODE_FILL_BOUNCE = 2'd0,
        MODE_SCAN        = 2'd1,
        MODE_BLINK       = 2'd2,
        MODE_FILL_ONCE   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/led_bar_animator_if.sv
// Control/status bundle of the LED-bar animator.
//   en, start, stop, mode, period : controller -> animator
//   O, busy, done                 : animator -> controller
// master = controller side, slave = animator side.
interface led_bar_animator_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIV_W = 10
) ();
    logic             en;
    logic             start;
    logic             stop;
    logic [1:0]       mode;
    logic [DIV_W-1:0] period;
    logic [WIDTH-1:0] O;
    logic             busy;
    logic             done;

    modport master (
        output en, start, stop, mode, period,
        input  O, busy, done
    );

    modport slave (
        input  en, start, stop, mode, period,
        output O, busy, done
    );
endinterface

// File: rtl/led_tick_gen.sv
// Programmable step prescaler. Counts enabled cycles and pulses tick when the
// count equals period, then wraps to 0, so a tick occurs every period+1 enabled cycles.
//   clk, rst : clock, synchronous active-high reset
//   clr      : return the count to 0 (restart/stop)
//   cnt_en   : count this cycle; when low the count is frozen
//   period   : terminal count (step period minus 1)
//   tick     : step strobe
module led_tick_gen #(
    parameter int unsigned DIV_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             cnt_en,
    input  logic [DIV_W-1:0] period,
    output logic             tick
);
    logic [DIV_W-1:0] cnt_q, cnt_d;

    assign tick = cnt_en && (cnt_q == period);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_en) begin
            cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/led_bar_animator.sv
// LED-bar pattern generator with four animations paced by an internal prescaler.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of led_bar_animator_if (en/start/stop/mode/period in,
//              O/busy/done out). O is registered and decoded from level/pos.
module led_bar_animator
    import led_anim_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIV_W = 10
) (
    input logic               clk,
    input logic               rst,
    led_bar_animator_if.slave bus
);
    localparam int unsigned LVL_W = $clog2(WIDTH + 1);
    localparam int unsigned POS_W = $clog2(WIDTH);

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [DIV_W-1:0] period_q, period_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             dir_up_q, dir_up_d;
    logic             phase_q, phase_d;
    logic [WIDTH-1:0] o_q, o_d;
    logic             done_q, done_d;
    logic             tick, clr;

    led_tick_gen #(
        .DIV_W (DIV_W)
    ) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .cnt_en (state_q == RUN && bus.en),
        .period (period_q),
        .tick   (tick)
    );

    // Top `lvl` LEDs lit.
    function automatic logic [WIDTH-1:0] therm(input logic [LVL_W-1:0] lvl);
        logic [WIDTH-1:0] m;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            m[i] = (32'(lvl) + i) >= WIDTH;
        end
        return m;
    endfunction

    function automatic logic [WIDTH-1:0] onehot(input logic [POS_W-1:0] p);
        logic [WIDTH-1:0] m;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            m[i] = (32'(p) == i);
        end
        return m;
    endfunction

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        period_d = period_q;
        level_d  = level_q;
        pos_d    = pos_q;
        dir_up_d = dir_up_q;
        phase_d  = phase_q;
        done_d   = 1'b0;
        clr      = 1'b0;

        if (bus.stop) begin
            state_d = IDLE;
            clr     = 1'b1;
        end else if (bus.start) begin
            state_d  = RUN;
            mode_d   = mode_e'(bus.mode);
            period_d = bus.period;
            clr      = 1'b1;
            level_d  = LVL_W'(1);
            pos_d    = POS_W'(WIDTH - 1);
            // SCAN begins at the top LED heading down; fills begin heading up.
            dir_up_d = (mode_e'(bus.mode) != MODE_SCAN);
            phase_d  = 1'b1;
        end else if (state_q == RUN && tick) begin
            unique case (mode_q)
                MODE_FILL_BOUNCE: begin
                    // Endpoints flip direction without moving, so they show for two ticks.
                    if (dir_up_q) begin
                        if (level_q == LVL_W'(WIDTH)) dir_up_d = 1'b0;
                        else                          level_d  = level_q + LVL_W'(1);
                    end else begin
                        if (level_q == LVL_W'(1)) dir_up_d = 1'b1;
                        else                      level_d  = level_q - LVL_W'(1);
                    end
                end
                MODE_SCAN: begin
                    // Endpoints bounce immediately, so they show once per sweep.
                    if (dir_up_q) begin
                        if (pos_q == POS_W'(WIDTH - 1)) begin
                            dir_up_d = 1'b0;
                            pos_d    = pos_q - POS_W'(1);
                        end else begin
                            pos_d = pos_q + POS_W'(1);
                        end
                    end else begin
                        if (pos_q == '0) begin
                            dir_up_d = 1'b1;
                            pos_d    = POS_W'(1);
                        end else begin
                            pos_d = pos_q - POS_W'(1);
                        end
                    end
                end
                MODE_BLINK: phase_d = ~phase_q;
                MODE_FILL_ONCE: begin
                    level_d = level_q + LVL_W'(1);
                    if (level_q == LVL_W'(WIDTH - 1)) begin
                        state_d = HOLD;
                        done_d  = 1'b1;
                    end
                end
            endcase
        end

        case (state_d)
            RUN: begin
                unique case (mode_d)
                    MODE_SCAN:  o_d = onehot(pos_d);
                    MODE_BLINK: o_d = phase_d ? '1 : '0;
                    default:    o_d = therm(level_d);
                endcase
            end
            HOLD:    o_d = '1;
            default: o_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            mode_q   <= MODE_FILL_BOUNCE;
            period_q <= '0;
            level_q  <= '0;
            pos_q    <= '0;
            dir_up_q <= 1'b1;
            phase_q  <= 1'b0;
            o_q      <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            period_q <= period_d;
            level_q  <= level_d;
            pos_q    <= pos_d;
            dir_up_q <= dir_up_d;
            phase_q  <= phase_d;
            o_q      <= o_d;
            done_q   <= done_d;
        end
    end

    assign bus.O    = o_q;
    assign bus.busy = (state_q == RUN);
    assign bus.done = done_q;
endmodule

// File: doc/led_bar_animator.md
Name: led_bar_animator

Overview:
- Parametrised LED-bar pattern generator for the FORTRESS front panel; the successor to the fixed 8-LED fill/drain block.
- Drives a WIDTH-bit LED bar with one of four selectable animations.
- Each step is paced by an internal programmable prescaler, so no external divided clock is needed.
- Supports start/stop control, enable-freeze, and a one-shot mode that reports completion.

Parameters:
- WIDTH, 8: number of LEDs; must be >= 2.
- DIV_W, 10: width of the step-period field and of the prescaler counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  step enable; when low, the prescaler and pattern freeze and O holds.
- start  input  1  one-cycle pulse; captures mode/period and (re)starts the animation.
- stop  input  1  one-cycle pulse; returns to IDLE and blanks the bar.
- mode  input  2  0 FILL_BOUNCE, 1 SCAN, 2 BLINK, 3 FILL_ONCE; sampled only on start.
- period  input  DIV_W  step period minus 1, in clk cycles; sampled only on start.
- O  output  WIDTH  LED drive; O[WIDTH-1] is the "top" LED; registered.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse when FILL_ONCE completes.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): O=0, busy=0, done=0, state=IDLE, prescaler=0, level=0, dir=up. rst overrides all other inputs.
- States and transitions:
  - IDLE -> RUN on start.
  - RUN -> IDLE on stop.
  - RUN -> HOLD when FILL_ONCE reaches level WIDTH.
  - HOLD -> IDLE on stop.
  - start in any state restarts RUN.
  - start and stop in the same cycle: stop wins.
- Start latency: the cycle after start, O shows step 0 of the selected pattern and busy=1.
- Prescaler:
  - Counts only while state=RUN and en=1.
  - tick asserts when the count equals the captured period; the counter then returns to 0.
  - Step advances every period+1 enabled cycles; period=0 advances every enabled cycle.
- FILL_BOUNCE:
  - O = the top `level` bits set.
  - level sequence: 1,2,…,WIDTH,WIDTH,WIDTH-1,…,1, then repeat.
  - Both endpoints are shown for two ticks; full period is 2*WIDTH ticks.
- SCAN:
  - Single lit LED at index pos, starting at WIDTH-1, moving down to 0, then back up.
  - Endpoints are not repeated; period is 2*WIDTH-2 ticks.
- BLINK: O alternates all-ones / all-zeros each tick, starting with all-ones.
- FILL_ONCE:
  - level runs 1..WIDTH, one step per tick.
  - On the tick that makes level=WIDTH: enter HOLD, O stays all-ones, busy=0, done=1 for exactly one cycle.
- IDLE: O=0. HOLD: O remains all-ones until stop or start.
- en low mid-animation: no state change; when en returns high, the step resumes with the remaining prescaler count.
- Restart mid-animation: prescaler is cleared, the pattern returns to step 0, and the new mode/period take effect.
- Changes on mode/period while running have no effect.
- Arithmetic:
  - level is a clog2(WIDTH+1)-bit counter; pos is a clog2(WIDTH)-bit counter.
  - O is decoded from level/pos via a thermometer or one-hot mask, never by shifting the previous O.

Decomposition:
- Package led_anim_pkg holds:
  - mode constants MODE_FILL_BOUNCE=0, MODE_SCAN=1, MODE_BLINK=2, MODE_FILL_ONCE=3;
  - state encoding IDLE/RUN/HOLD.
- One sub-module, led_tick_gen (DIV_W): clk, rst, clr, cnt_en, period in, tick out.
- FSM, level/pos/dir counters and O decode live in led_bar_animator.

Test Plan:
1. WIDTH=8, rst then start with mode=0, period=0, en=1 -> O sequence 80,C0,E0,F0,F8,FC,FE,FF,FF,FE,…,80,80,C0 (hex), one value per cycle; busy=1 throughout.
2. mode=1, period=2 -> O = 80 for 3 cycles, 40 for 3, … 01, 02, …, 80; 80 and 01 each appear once per 14-tick period.
3. mode=3, period=0 -> O = 80,C0,…,FF after 8 ticks; done=1 for exactly one cycle on entry to HOLD, busy falls the same cycle, and FF holds for 20 more cycles until stop gives O=00.
4. mode=2, period=1, toggle en low for 5 cycles mid-period -> O frozen during en=0; the edge resumes with the remaining count (FF,FF,00,00 pattern, stretched by exactly 5 cycles).
5. FILL_BOUNCE running at level 5, assert start(mode=1) and stop in the same cycle -> next cycle O=00, busy=0, state IDLE. Separately, start alone -> O=80, SCAN from step 0.
6. rst asserted mid-BLINK with O=FF -> next cycle O=00, busy=0, done=0. start after rst deasserts -> normal step 0.
